// File: rtl/mash_pkg.sv
// Shared types and constants for the MASH recombination path.
package mash_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_t;

  // Smallest signed width that holds the recombined range.
  function automatic int min_out_w(input int stages);
    return (stages <= 2) ? 3 : 4;
  endfunction

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) begin
      r = r * (n - i) / (i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/mash_diff.sv
// (1 - z^-1)^K differentiator on a single-bit stream.
// History advances only on accepted samples.
module mash_diff
  import mash_pkg::*;
#(
  parameter int K = 1,
  parameter int W = 4
) (
  input  logic                clck,
  input  logic                rst,
  input  logic                en,
  input  logic                d,
  output logic signed [W-1:0] y
);

  logic [K-1:0] hist;
  logic [K:0]   x;

  assign x = {hist, d};

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (en) begin
      hist <= K'({hist, d});
    end
  end

  // Tap i weight is (-1)^i * C(K,i); x[0] is the current sample.
  function automatic logic signed [W-1:0] coef(input int i);
    int c;
    c = binom(K, i);
    if ((i % 2) != 0) c = -c;
    return W'(c);
  endfunction

  always_comb begin
    y = '0;
    for (int i = 0; i <= K; i++) begin
      if (x[i]) y = y + coef(i);
    end
  end

endmodule

// File: rtl/mash_noise_cancel.sv
// MASH noise-cancellation stage: differentiates and sums stage carries
// into one signed multi-level code, gated by a history-fill FSM.
module mash_noise_cancel
  import mash_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int OUT_W      = 4
) (
  input  logic                    clck,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    c1,
  input  logic                    c2,
  input  logic                    c3,
  input  logic                    mute,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    y_valid
);

  if (NUM_STAGES < STAGES_MIN || NUM_STAGES > STAGES_MAX) begin : g_bad_stages
    $error("mash_noise_cancel: NUM_STAGES must be 2 or 3");
  end
  if (OUT_W < min_out_w(NUM_STAGES)) begin : g_bad_width
    $error("mash_noise_cancel: OUT_W too small for NUM_STAGES");
  end

  localparam logic [1:0] FILL_LAST = 2'(NUM_STAGES - 2);

  logic signed [OUT_W-1:0] e1;
  logic signed [OUT_W-1:0] d2;
  logic signed [OUT_W-1:0] d3;
  logic signed [OUT_W-1:0] y_sum;

  fill_state_t state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        take;

  assign e1 = {{(OUT_W-1){1'b0}}, c1};

  mash_diff #(.K(1), .W(OUT_W)) u_d2 (
    .clck (clck),
    .rst  (rst),
    .en   (en),
    .d    (c2),
    .y    (d2)
  );

  if (NUM_STAGES == 3) begin : g_s3
    mash_diff #(.K(2), .W(OUT_W)) u_d3 (
      .clck (clck),
      .rst  (rst),
      .en   (en),
      .d    (c3),
      .y    (d3)
    );
  end else begin : g_s2
    logic unused_c3;
    assign unused_c3 = c3;
    assign d3 = '0;
  end

  assign y_sum = e1 + d2 + d3;
  assign take  = en && (state_q == RUN);

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (en) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == FILL_LAST) state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      y_out   <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= take;
      if (take) y_out <= mute ? '0 : y_sum;
    end
  end

endmodule

// File: tb/tb_mash_noise_cancel.sv
// Directed bench for mash_noise_cancel (NUM_STAGES=3, OUT_W=4).
module tb_mash_noise_cancel;

  logic              clck;
  logic              rst;
  logic              en;
  logic              c1, c2, c3, mute;
  logic signed [3:0] y_out;
  logic              y_valid;

  int nchk;
  int npass;

  mash_noise_cancel #(.NUM_STAGES(3), .OUT_W(4)) dut (
    .clck    (clck),
    .rst     (rst),
    .en      (en),
    .c1      (c1),
    .c2      (c2),
    .c3      (c3),
    .mute    (mute),
    .y_out   (y_out),
    .y_valid (y_valid)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs == exp) npass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic smp(input logic a, input logic b, input logic c,
                     input logic m);
    c1 = a; c2 = b; c3 = c; mute = m; en = 1'b1;
    @(posedge clck);
    #1;
  endtask

  task automatic idle();
    en = 1'b0;
    @(posedge clck);
    #1;
  endtask

  task automatic chk_out(input string tag, input int v, input int y);
    chk({tag, "_v"}, int'(y_valid), v);
    chk({tag, "_y"}, int'(y_out), y);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    nchk = 0; npass = 0;
    rst = 1'b0; en = 1'b0;
    c1 = 0; c2 = 0; c3 = 0; mute = 0;
    repeat (2) @(posedge clck);
    #1;
    chk_out("rst", 0, 0);
    rst = 1'b1;

    // fill: third accepted sample is the first valid one
    smp(0, 0, 0, 0); chk_out("fill1", 0, 0);
    smp(0, 0, 0, 0); chk_out("fill2", 0, 0);
    smp(0, 0, 0, 0); chk_out("fill3", 1, 0);
    idle();          chk_out("fill_idle", 0, 0);

    // c3 step 0,1,0,0 -> 0,+1,-2,+1
    smp(0, 0, 0, 0); chk_out("step0", 1, 0);
    smp(0, 0, 1, 0); chk_out("step1", 1, 1);
    smp(0, 0, 0, 0); chk_out("step2", 1, -2);
    smp(0, 0, 0, 0); chk_out("step3", 1, 1);

    // extremes
    smp(0, 1, 1, 0); chk_out("pre_min", 1, 2);
    smp(0, 0, 0, 0); chk_out("min", 1, -3);
    chk("min_bits", int'(y_out[3:0]), 13);
    smp(1, 1, 1, 0); chk_out("max", 1, 4);
    chk("max_bits", int'(y_out[3:0]), 4);

    // constant input with idle gaps
    idle();
    smp(1, 1, 1, 0); chk_out("const_prime", 1, 0);
    for (int i = 0; i < 10; i++) begin
      repeat (3) idle();
      chk_out("const_gap", 0, (i == 0) ? 0 : 1);
      smp(1, 1, 1, 0);
      chk_out("const", 1, 1);
    end

    // drain history back to zero, then muted step pattern
    smp(0, 0, 0, 0); chk_out("drain0", 1, -2);
    smp(0, 0, 0, 0); chk_out("drain1", 1, 1);
    smp(0, 0, 0, 0); chk_out("mute0", 1, 0);
    smp(0, 0, 1, 1); chk_out("mute1", 1, 0);
    smp(0, 0, 0, 1); chk_out("mute2", 1, 0);
    smp(0, 0, 0, 0); chk_out("mute3", 1, 1);

    // asynchronous reset between edges
    smp(1, 0, 0, 0); chk_out("prerst", 1, 1);
    #2 rst = 1'b0;
    #1;
    chk_out("async_rst", 0, 0);
    en = 1'b0;
    @(posedge clck);
    #2 rst = 1'b1;
    @(negedge clck);
    smp(1, 0, 0, 0); chk_out("refill1", 0, 0);
    smp(1, 0, 0, 0); chk_out("refill2", 0, 0);
    smp(1, 0, 0, 0); chk_out("resume", 1, 1);
    idle();          chk_out("end_idle", 0, 1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/mash_noise_cancel.md
Name: mash_noise_cancel

Overview:
- Recombination (noise-cancellation) stage of the MASH sigma-delta DAC. Sits directly downstream of the cascaded accumulator stages (PART_1 and siblings).
- Takes the per-stage carry bits, applies the digital differentiators (1-z^-1)^(k-1) and sums them into one multi-level signed code.
- Drives the DAC output element.
- Timing is set by a sample strobe; a small fill state machine suppresses output until the differentiator history is valid.

Parameters:
- NUM_STAGES, 3, number of MASH stages combined; legal values 2 or 3.
- OUT_W, 4, output width in bits, signed; must be at least 3 for NUM_STAGES=2 and at least 4 for NUM_STAGES=3.

Ports:
- clck  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; one carry set is accepted on each clck edge where en=1.
- c1  input  1  carry of stage 1.
- c2  input  1  carry of stage 2.
- c3  input  1  carry of stage 3; ignored when NUM_STAGES=2.
- mute  input  1  synchronous mute; forces y_out to zero while high.
- y_out  output  OUT_W  signed recombined code.
- y_valid  output  1  one-cycle pulse: y_out updated this cycle.

Behaviour:
- Reset (rst=0, asynchronous): y_out=0, y_valid=0, history registers c2_d1, c3_d1, c3_d2 = 0, fill counter = 0, state = FILL.
- Release is synchronous to clck; the first edge after rst rises may already accept a sample.
- Carries are unsigned 0/1 and are extended to signed OUT_W before any arithmetic.
- Per accepted sample n:
  - d2 = c2[n] - c2[n-1], range -1..1.
  - d3 = c3[n] - 2*c3[n-1] + c3[n-2], range -2..2.
  - NUM_STAGES=3: y = c1 + d2 + d3, range -3..4.
  - NUM_STAGES=2: y = c1 + d2, range -1..2.
  - No saturation is needed; the range fits OUT_W by the parameter rule.
- Latency: y_out and y_valid are registered, so both appear exactly 1 clck after the en edge.
- With en=0: y_out holds, y_valid=0, history does not shift.
- State machine:
  - FILL: each accepted sample shifts history and increments the fill counter. y_valid stays 0 and y_out stays 0. After NUM_STAGES-1 accepted samples, go to RUN.
  - RUN: each accepted sample registers y and pulses y_valid=1.
  - The sample that completes FILL does not produce a valid output. The first valid output is sample NUM_STAGES.
- mute:
  - Sampled on accepted samples only.
  - If mute=1 on an accepted sample: y_out is registered as 0, y_valid still pulses in RUN, and history still shifts so the differentiators stay coherent.
  - mute has no effect on the state machine.
- en=1 on back-to-back clck edges is legal; one sample is accepted per edge and the output is fully pipelined.
- Reset mid-operation: all state clears immediately, y_valid drops in the same instant, and the block re-enters FILL.
- Invalid parameter values must fail elaboration via a generate-time check.

Decomposition:
- Shared package mash_pkg holds: the NUM_STAGES legal-range constants, the minimum-OUT_W function, and the FILL/RUN state enum (shared with the stage controller).
- One natural sub-module: mash_diff. It is a parameterised (1-z^-1)^k differentiator on a 1-bit input, with an en-gated history shift and a signed output. It is instantiated once per stage 2..NUM_STAGES.
- Summation and the fill FSM remain in the top level.

Test Plan:
1. Reset and fill. Hold rst=0 for 2 cycles, release, then pulse en with c1=c2=c3=0 three times.
   - Required: y_valid=0 for the first 2 accepted samples, then a single y_valid=1 pulse one cycle after the third, with y_out=0.
2. Differentiator step (NUM_STAGES=3, in RUN). Apply c1=0, c2=0, c3 sequence 0,1,0,0.
   - Required: y_out sequence 0, +1, -2, +1.
3. Extreme values. From history c2=1, c3_d1=1, c3_d2=0, apply c1=0, c2=0, c3=0.
   - Required: y = 0 - 1 - 2 + 0 = -3, i.e. y_out=4'b1101.
   - Then from history c2=0, c3_d1=0, c3_d2=1, apply c1=1, c2=1, c3=1.
   - Required: y = 1 + 1 + 1 + 1 = +4, i.e. y_out=4'b0100. Check no wrap.
4. Constant input. c1=1 with c2, c3 steady at 1 for 10 samples.
   - Required: y_out=+1 on every y_valid pulse.
   - With en gaps of 3 idle cycles between samples, y_out holds between pulses.
5. Mute. Assert mute for 2 samples in the middle of the pattern from scenario 2.
   - Required: y_out=0 and y_valid pulses during mute.
   - The first unmuted output equals the unmuted reference value, showing history kept shifting.
6. Reset mid-run. Drive rst=0 between clck edges during RUN.
   - Required: y_out=0 and y_valid=0 immediately, without waiting for a clock.
   - After release, 2 accepted samples pass with no y_valid before output resumes.
